// File: rtl/disp_column_median.sv
// Column-wise 3-tap median on the disparity field of a column-major stream.
// Optional hole filling of zero disparities: define DISP_COLUMN_HOLE_FILL_EN.
module disp_column_median #(
  parameter int width      = 120,
  parameter int height     = 240,
  parameter int data_width = 21,
  parameter int disp_bits  = 8,
  parameter int tag_cols   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_col_start,
  output logic                  out_frame_start
);

  localparam int RW = (height > 1) ? $clog2(height) : 1;
  localparam int CW = (width > 1) ? $clog2(width) : 1;

  localparam logic [RW-1:0] LAST_ROW = RW'(height - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(width - 1);
  localparam logic [CW:0]   TAG_LIM  = (CW + 1)'(tag_cols);

  typedef logic [data_width-1:0] word_t;
  typedef logic [disp_bits-1:0]  disp_t;

  logic [RW-1:0] in_row;
  logic [CW-1:0] in_col;

  word_t prev;
  word_t cur;
  logic  flush;

  logic  is_tag;
  logic  top;
  word_t sample;
  word_t med;

  // Pick the word whose disparity is the median; ties go to b, then a.
  function automatic word_t median3(word_t a, word_t b, word_t c);
    disp_t da;
    disp_t db;
    disp_t dc;
    da = a[disp_bits-1:0];
    db = b[disp_bits-1:0];
    dc = c[disp_bits-1:0];
    if ((da <= db && db <= dc) || (dc <= db && db <= da)) begin
      return b;
    end else if ((db <= da && da <= dc) || (dc <= da && da <= db)) begin
      return a;
    end else begin
      return c;
    end
  endfunction

  assign is_tag = {1'b0, in_col} < TAG_LIM;

  // The output row (in_row-1) is a column top when it is row 0, or
  // row 1 of a tagged column whose row 0 is excluded from filtering.
  assign top = (in_row == RW'(1))
            || (is_tag && in_row == RW'(2));

  assign med = median3(prev, cur, sample);

`ifdef DISP_COLUMN_HOLE_FILL_EN
  word_t fill;
  word_t fill_eff;
  logic  raw_tag;
  logic  hole;

  assign raw_tag  = is_tag && (in_row == '0);
  assign fill_eff = (in_row == '0) ? '0 : fill;
  assign hole     = !raw_tag && (in_data[disp_bits-1:0] == '0);
  assign sample   = hole ? fill_eff : in_data;

  // Remember the last non-zero filled sample of the current column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= '0;
    end else if (in_valid) begin
      if (raw_tag) begin
        fill <= '0;
      end else begin
        fill <= sample;
      end
    end
  end
`else
  assign sample = in_data;
`endif

  // Row/column position of the next accepted sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_row <= '0;
      in_col <= '0;
    end else if (in_valid) begin
      if (in_row == LAST_ROW) begin
        in_row <= '0;
        if (in_col == LAST_COL) begin
          in_col <= '0;
        end else begin
          in_col <= in_col + CW'(1);
        end
      end else begin
        in_row <= in_row + RW'(1);
      end
    end
  end

  // Two-deep sample history plus the pending bottom-row flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= '0;
      cur   <= '0;
      flush <= 1'b0;
    end else begin
      if (in_valid) begin
        prev <= cur;
        cur  <= sample;
      end
      flush <= in_valid && (in_row == LAST_ROW);
    end
  end

  // Registered outputs; the flush slot and a median output never coincide
  // because the sample after a bottom row is always a row 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_col_start   <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      out_valid       <= 1'b0;
      out_col_start   <= 1'b0;
      out_frame_start <= 1'b0;
      if (flush) begin
        out_valid <= 1'b1;
        out_data  <= cur;
      end else if (in_valid && in_row != '0) begin
        out_valid       <= 1'b1;
        out_data        <= top ? cur : med;
        out_col_start   <= (in_row == RW'(1));
        out_frame_start <= (in_row == RW'(1)) && (in_col == '0);
      end
    end
  end

endmodule

// File: tb/tb_disp_column_median.sv
// Directed bench for disp_column_median (width=3, height=4, tag_cols=1).
// Table of whole columns plus hand-timed latency and reset sequences.
module tb_disp_column_median;

  localparam int W  = 3;
  localparam int H  = 4;
  localparam int DW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_col_start;
  logic          out_frame_start;

  always #5 clk = ~clk;

  disp_column_median #(
    .width(W),
    .height(H),
    .data_width(DW),
    .disp_bits(8),
    .tag_cols(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_col_start(out_col_start),
    .out_frame_start(out_frame_start)
  );

  typedef struct {
    logic [3:0][DW-1:0] din;
    int                 gap;
    logic [3:0][DW-1:0] dout;
    logic               fs;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  logic [DW+1:0] oq[$];

  always @(negedge clk) begin
    if (out_valid) begin
      oq.push_back({out_frame_start, out_col_start, out_data});
    end else if (out_col_start || out_frame_start) begin
      viol++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [DW-1:0] i0, i1, i2, i3,
    input int g,
    input logic [DW-1:0] o0, o1, o2, o3,
    input logic fs);
    vec_t v;
    v.din[0] = i0; v.din[1] = i1;
    v.din[2] = i2; v.din[3] = i3;
    v.gap = g;
    v.dout[0] = o0; v.dout[1] = o1;
    v.dout[2] = o2; v.dout[3] = o3;
    v.fs = fs;
    return v;
  endfunction

  vec_t tbl[6];

  initial begin
    tbl[0] = mk(21'h1F0003, 21'h4, 21'h8, 21'h6, 0,
                21'h1F0003, 21'h4, 21'h6, 21'h6, 1'b1);
    tbl[1] = mk(21'h5, 21'h9, 21'h2, 21'h7, 1,
                21'h5, 21'h5, 21'h7, 21'h7, 1'b0);
`ifdef DISP_COLUMN_HOLE_FILL_EN
    tbl[2] = mk(21'h4, 21'h0, 21'h0, 21'h9, 0,
                21'h4, 21'h4, 21'h4, 21'h9, 1'b0);
`else
    tbl[2] = mk(21'h4, 21'h0, 21'h0, 21'h9, 0,
                21'h4, 21'h0, 21'h0, 21'h9, 1'b0);
`endif
    tbl[3] = mk(21'h0A0000, 21'h3, 21'h3, 21'h1, 0,
                21'h0A0000, 21'h3, 21'h3, 21'h1, 1'b1);
    tbl[4] = mk(21'h100005, 21'h200005, 21'h300005, 21'h400001, 0,
                21'h100005, 21'h200005, 21'h300005, 21'h400001, 1'b0);
    tbl[5] = mk(21'h010007, 21'h020003, 21'h030007, 21'h040002, 0,
                21'h010007, 21'h010007, 21'h020003, 21'h040002, 1'b0);

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_col_start", 32'(out_col_start), 0);
    chk("rst_frame_start", 32'(out_frame_start), 0);
    reset = 1'b0;

    // two back-to-back frames from the table
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 4; r++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = tbl[i].din[r];
        for (int g = 0; g < tbl[i].gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    chk("out_count", 32'(oq.size()), 24);
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 4; r++) begin
        int idx;
        idx = i * 4 + r;
        if (idx < oq.size()) begin
          chk($sformatf("data_c%0d_r%0d", i, r),
              32'(oq[idx][DW-1:0]), 32'(tbl[i].dout[r]));
          chk($sformatf("col_start_c%0d_r%0d", i, r),
              32'(oq[idx][DW]), 32'(r == 0));
          chk($sformatf("frame_start_c%0d_r%0d", i, r),
              32'(oq[idx][DW+1]), 32'(r == 0 && tbl[i].fs));
        end
      end
    end

    // latency: frame 3 column 0 with long gaps
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 21'h150000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("lat_idle%0d", k), 32'(out_valid), 0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 21'h010002;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_r0_valid", 32'(out_valid), 1);
    chk("lat_r0_data", 32'(out_data), 32'h150000);
    chk("lat_r0_col_start", 32'(out_col_start), 1);
    chk("lat_r0_frame_start", 32'(out_frame_start), 1);
    @(negedge clk);
    chk("lat_pulse_end", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_data  = 21'h020009;
    @(negedge clk);
    in_data  = 21'h030004;
    chk("lat_r1_valid", 32'(out_valid), 1);
    chk("lat_r1_data", 32'(out_data), 32'h010002);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_r2_valid", 32'(out_valid), 1);
    chk("lat_r2_data", 32'(out_data), 32'h030004);
    @(negedge clk);
    chk("lat_r3_flush_valid", 32'(out_valid), 1);
    chk("lat_r3_flush_data", 32'(out_data), 32'h030004);
    chk("lat_r3_col_start", 32'(out_col_start), 0);
    @(negedge clk);
    chk("lat_after_flush", 32'(out_valid), 0);

    // asynchronous reset after row 2 of column 1
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 21'h5;
    @(negedge clk);
    in_data  = 21'h6;
    @(negedge clk);
    in_data  = 21'h7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_data", 32'(out_data), 32'h6);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    chk("async_rst_col_start", 32'(out_col_start), 0);
    chk("async_rst_frame_start", 32'(out_frame_start), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 21'h1ABCDE;
    @(negedge clk);
    in_data  = 21'h000001;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_data", 32'(out_data), 32'h1ABCDE);
    chk("post_rst_col_start", 32'(out_col_start), 1);
    chk("post_rst_frame_start", 32'(out_frame_start), 1);
    repeat (3) @(negedge clk);
    chk("post_rst_quiet", 32'(out_valid), 0);

    chk("flag_qualified", 32'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disp_column_median.md
DISP_COLUMN_MEDIAN -- requirements
Module: disp_column_median

Interface
REQ-001 SHALL have parameter width, default 120: columns per frame.
REQ-002 SHALL have parameter height, default 240: samples per column, height >= 4.
REQ-003 SHALL have parameter data_width, default 21: sample word width.
REQ-004 SHALL have parameter disp_bits, default 8: disparity field is in_data[disp_bits-1:0], compared as unsigned.
REQ-005 SHALL have parameter tag_cols, default 32: leading columns whose row-0 word is a frame tag, 0 <= tag_cols <= width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-008 SHALL have port in_data, input, data_width: column-major transposed stream, one column top-to-bottom, columns left-to-right.
REQ-009 SHALL have port in_valid, input, 1: in_data accepted every cycle it is high; there is no backpressure.
REQ-010 SHALL have port out_data, output, data_width: filtered word.
REQ-011 SHALL have port out_valid, output, 1: out_data qualifier.
REQ-012 SHALL have port out_col_start, output, 1: high with the row-0 output of each column.
REQ-013 SHALL have port out_frame_start, output, 1: high with the row-0 column-0 output of each frame.

Function
REQ-014 SHALL track the input position with in_row (0..height-1) and in_col (0..width-1), advancing on in_valid: in_row wraps and increments in_col, and in_col wraps at width-1 to start a new frame.
REQ-015 SHALL output row r of a column (r < height-1) on the cycle after the input at row r+1 is accepted.
REQ-016 SHALL output row height-1 two cycles after its input is accepted, as a flush slot.
REQ-017 SHALL never produce two outputs in one cycle, including when in_valid is continuously high.
REQ-018 SHALL output rows 0 and height-1 equal to their input (edge replication, median(x,x,y)=x).
REQ-019 SHALL output interior row r as the whole input word whose disparity field is the median of rows r-1, r and r+1.
REQ-020 SHALL resolve equal disparity fields in favour of row r, then row r-1.
REQ-021 SHALL, for in_col < tag_cols, pass row 0 verbatim and exclude it from the median.
REQ-022 SHALL, in such a column, treat row 1 as the column top, so row 1's output equals row 1's input.
REQ-023 SHALL never let a column's median use samples from another column or frame.
REQ-024 SHALL register all outputs; out_col_start and out_frame_start SHALL only be high when out_valid is high.
REQ-025 SHALL make out_data don't-care when out_valid is low, but hold it stable.

Reset
REQ-026 SHALL, on reset assertion (asynchronous, any cycle including mid-column), immediately clear out_valid, out_col_start, out_frame_start, out_data, in_row, in_col, the sample pipeline and any pending flush.
REQ-027 SHALL treat the first accepted sample after reset deassertion as row 0, column 0 of a new frame.

Configuration
REQ-028 SHALL use macro DISP_COLUMN_HOLE_FILL_EN to select hole filling.
REQ-029 SHALL, with DISP_COLUMN_HOLE_FILL_EN defined, replace each non-tag sample whose disparity field is 0 before the median with the last non-zero filled sample of the same column.
REQ-030 SHALL, with DISP_COLUMN_HOLE_FILL_EN defined, use all-zero words as the fill value until the first non-zero sample of the column.
REQ-031 SHALL, without DISP_COLUMN_HOLE_FILL_EN, treat zero as an ordinary value; latency is identical with and without the macro.

Verification (width=3, height=4, disp_bits=8, tag_cols=1 unless stated)
REQ-032 SHALL cover: column 1 with in_valid every other cycle, disparities 5,9,2,7 -> outputs 5,5,7,7; row 0 marked with out_col_start.
REQ-033 SHALL cover: in_valid held high for 12 samples -> exactly 12 out_valid pulses, one per cycle maximum, with out_frame_start only on the first.
REQ-034 SHALL cover: column 0 input 0x1F0003,4,8,6 -> outputs 0x1F0003,4,6,6; the tag word is not used in the median.
REQ-035 SHALL cover: with DISP_COLUMN_HOLE_FILL_EN, column 1 input 4,0,0,9 -> filled 4,4,4,9 -> outputs 4,4,4,9; without the macro -> outputs 4,0,0,9.
REQ-036 SHALL cover: reset asserted after row 2 of column 1 -> all outputs low asynchronously, then the next sample is output with out_frame_start.
REQ-037 SHALL cover: two back-to-back frames -> out_frame_start at output indices 0 and 12 and out_col_start every 4th output.
